// File: rtl/bsr_pkg.sv
// Shared definitions for the boundary-scan register chain: output mode encodings and default width.
package bsr_pkg;

    localparam int BSR_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        BSR_MODE_TRANSPARENT = 2'b00,
        BSR_MODE_EXTEST      = 2'b01,
        BSR_MODE_CLAMP       = 2'b10,
        BSR_MODE_RSVD        = 2'b11
    } bsr_mode_e;

endpackage

// File: rtl/bsr_len_check.sv
// Shift counter and sticky length-error flag for the boundary-scan chain.
module bsr_len_check #(
    parameter int WIDTH = bsr_pkg::BSR_DEF_WIDTH,
    parameter int CNTW  = $clog2(WIDTH + 1) + 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            i_capture,
    input  logic            i_shift,
    input  logic            i_update,
    output logic [CNTW-1:0] o_count,
    output logic            o_len_err
);

    localparam logic [CNTW-1:0] LP_SAT   = '1;
    localparam logic [CNTW-1:0] LP_WIDTH = CNTW'(WIDTH);

    logic [CNTW-1:0] r_count;
    logic            r_len_err;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count   <= '0;
            r_len_err <= 1'b0;
        end else begin
            if (i_capture)
                r_count <= '0;
            else if (i_shift && r_count != LP_SAT)
                r_count <= r_count + 1'b1;

            // A bad update wins over a coincident capture; the flag only clears on a lone capture.
            if (i_update && r_count != LP_WIDTH)
                r_len_err <= 1'b1;
            else if (i_capture && !i_update)
                r_len_err <= 1'b0;
        end
    end

    assign o_count   = r_count;
    assign o_len_err = r_len_err;

endmodule

// File: rtl/bsr_chain.sv
// Parametrised boundary-scan register: shift stage, update stage and 2-bit output mode mux.
// Define BSR_SAFE_RESET_EN to reset the update stage to SAFE_VALUE instead of zero.
module bsr_chain
    import bsr_pkg::*;
#(
    parameter int               WIDTH      = BSR_DEF_WIDTH,
    parameter int               CNTW       = $clog2(WIDTH + 1) + 1,
    parameter logic [WIDTH-1:0] SAFE_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_IN,
    input  logic             ShiftIn,
    input  logic             CaptureDR,
    input  logic             ShiftDR,
    input  logic             UpdateDR,
    input  logic [1:0]       Mode,
    output logic [WIDTH-1:0] Data_OUT,
    output logic             ShiftOut,
    output logic [CNTW-1:0]  ShiftCount,
    output logic             LenErr
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_ur;
    logic [WIDTH-1:0] w_sr_shifted;

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sr_shifted = ShiftIn;
        end else begin : g_wn
            assign w_sr_shifted = {ShiftIn, r_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            r_sr <= '0;
        else if (CaptureDR)
            r_sr <= Data_IN;
        else if (ShiftDR)
            r_sr <= w_sr_shifted;
    end

    // UR samples the pre-edge SR, so update may coincide with shift or capture.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
`ifdef BSR_SAFE_RESET_EN
            r_ur <= SAFE_VALUE;
`else
            r_ur <= '0;
`endif
        else if (UpdateDR)
            r_ur <= r_sr;
    end

    always_comb begin
        Data_OUT = r_ur;
        case (Mode)
            BSR_MODE_TRANSPARENT: Data_OUT = Data_IN;
            BSR_MODE_CLAMP:       Data_OUT = SAFE_VALUE;
            default:              Data_OUT = r_ur;
        endcase
    end

    assign ShiftOut = r_sr[0];

    bsr_len_check #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_len_check (
        .Clock     (Clock),
        .Reset     (Reset),
        .i_capture (CaptureDR),
        .i_shift   (ShiftDR),
        .i_update  (UpdateDR),
        .o_count   (ShiftCount),
        .o_len_err (LenErr)
    );

endmodule

// File: tb/tb_bsr_chain.sv
// Scoreboard bench for bsr_chain: expectations queued with stimulus, compared after each edge.
module tb_bsr_chain;

    localparam int               W    = 8;
    localparam int               CW   = $clog2(W + 1) + 1;
    localparam logic [W-1:0]     SAFE = 8'h5A;

    localparam int S_DOUT = 0;
    localparam int S_SO   = 1;
    localparam int S_CNT  = 2;
    localparam int S_ERR  = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } sb_t;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [W-1:0]  Data_IN;
    logic          ShiftIn;
    logic          CaptureDR;
    logic          ShiftDR;
    logic          UpdateDR;
    logic [1:0]    Mode;
    logic [W-1:0]  Data_OUT;
    logic          ShiftOut;
    logic [CW-1:0] ShiftCount;
    logic          LenErr;

    int  n_chk = 0;
    int  n_err = 0;
    sb_t sb[$];

    bsr_chain #(.WIDTH(W), .SAFE_VALUE(SAFE)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Data_IN    (Data_IN),
        .ShiftIn    (ShiftIn),
        .CaptureDR  (CaptureDR),
        .ShiftDR    (ShiftDR),
        .UpdateDR   (UpdateDR),
        .Mode       (Mode),
        .Data_OUT   (Data_OUT),
        .ShiftOut   (ShiftOut),
        .ShiftCount (ShiftCount),
        .LenErr     (LenErr)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t         e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_DOUT:  obs = 32'(Data_OUT);
                S_SO:    obs = 32'(ShiftOut);
                S_CNT:   obs = 32'(ShiftCount);
                default: obs = 32'(LenErr);
            endcase
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        drain();
    endtask

    task automatic idle();
        CaptureDR = 1'b0;
        ShiftDR   = 1'b0;
        UpdateDR  = 1'b0;
    endtask

    task automatic shift_n(input int n, input logic si);
        ShiftDR = 1'b1;
        ShiftIn = si;
        for (int i = 0; i < n; i++) cyc();
        ShiftDR = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] rst_ur;
`ifdef BSR_SAFE_RESET_EN
        rst_ur = SAFE;
`else
        rst_ur = '0;
`endif
        Reset = 1'b1; Data_IN = '0; ShiftIn = 1'b0; Mode = 2'b01;
        idle();
        #1;
        expect_v("rst_dout", S_DOUT, 32'(rst_ur));
        expect_v("rst_so",   S_SO,   0);
        expect_v("rst_err",  S_ERR,  0);
        expect_v("rst_cnt",  S_CNT,  0);
        drain();
        @(posedge Clock); #1;
        Reset = 1'b0;

        // capture A5 then shift out LSB-first with ones entering
        pat = 8'hA5;
        Data_IN = pat; CaptureDR = 1'b1;
        expect_v("cap_so", S_SO, 1);
        expect_v("cap_cnt", S_CNT, 0);
        cyc();
        CaptureDR = 1'b0; ShiftDR = 1'b1; ShiftIn = 1'b1;
        for (int i = 1; i <= W; i++) begin
            expect_v($sformatf("so_%0d", i), S_SO, (i < W) ? 32'(pat[i]) : 32'd1);
            cyc();
        end
        ShiftDR = 1'b0;
        expect_v("cnt8", S_CNT, 8);
        expect_v("err_pre_upd", S_ERR, 0);
        drain();

        UpdateDR = 1'b1;
        expect_v("upd_dout_ff", S_DOUT, 32'hFF);
        expect_v("upd_err_ok", S_ERR, 0);
        cyc();
        UpdateDR = 1'b0;

        Mode = 2'b00; Data_IN = 8'h3C; #1;
        expect_v("transp", S_DOUT, 32'h3C); drain();
        Mode = 2'b10; #1;
        expect_v("clamp", S_DOUT, 32'(SAFE)); drain();
        Mode = 2'b11; #1;
        expect_v("rsvd", S_DOUT, 32'hFF); drain();
        Mode = 2'b01;

        // short shift sequence: update still happens, error raised, lone capture clears
        Data_IN = 8'hC3; CaptureDR = 1'b1; cyc(); CaptureDR = 1'b0;
        shift_n(7, 1'b0);
        UpdateDR = 1'b1;
        expect_v("short_dout", S_DOUT, 32'h01);
        expect_v("short_err", S_ERR, 1);
        expect_v("short_cnt", S_CNT, 7);
        cyc();
        UpdateDR = 1'b0;
        Data_IN = 8'h81; CaptureDR = 1'b1;
        expect_v("clr_err", S_ERR, 0);
        expect_v("clr_cnt", S_CNT, 0);
        cyc();
        CaptureDR = 1'b0;

        // update coincident with shift takes the old SR (81); SR becomes 40
        UpdateDR = 1'b1; ShiftDR = 1'b1; ShiftIn = 1'b0;
        expect_v("co_dout", S_DOUT, 32'h81);
        expect_v("co_so", S_SO, 0);
        expect_v("co_err", S_ERR, 1);
        cyc();
        idle();
        shift_n(5, 1'b0);
        expect_v("sr40_so_pre", S_SO, 0); drain();
        shift_n(1, 1'b0);
        expect_v("sr40_so", S_SO, 1); drain();

        // saturation: no wrap, update flags an error
        CaptureDR = 1'b1; cyc(); CaptureDR = 1'b0;
        expect_v("cap_err_clr", S_ERR, 0); drain();
        shift_n(40, 1'b0);
        expect_v("sat_cnt", S_CNT, 31); drain();
        UpdateDR = 1'b1;
        expect_v("sat_err", S_ERR, 1);
        cyc();
        UpdateDR = 1'b0;

        // asynchronous reset in the middle of a shift sequence
        CaptureDR = 1'b1; Data_IN = 8'hF0; cyc(); CaptureDR = 1'b0;
        ShiftDR = 1'b1; ShiftIn = 1'b1; cyc(); cyc();
        Reset = 1'b1; #1;
        expect_v("mid_rst_dout", S_DOUT, 32'(rst_ur));
        expect_v("mid_rst_cnt", S_CNT, 0);
        expect_v("mid_rst_err", S_ERR, 0);
        expect_v("mid_rst_so", S_SO, 0);
        drain();
        idle();
        @(posedge Clock); #1;
        Reset = 1'b0;

        // no capture since reset: exactly WIDTH shifts is still clean
        shift_n(W, 1'b1);
        UpdateDR = 1'b1;
        expect_v("nocap_err", S_ERR, 0);
        expect_v("nocap_dout", S_DOUT, 32'hFF);
        cyc();
        UpdateDR = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
